// File: rtl/mem_resp_port.sv
// ============================================================================
// Module   : mem_resp_port
// Brief    : Word-wide req/ready memory responder with fixed access latency,
//            range error reporting and per-direction completion counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_resp_port #(
  parameter int                DWidth   = 32,
  parameter int                Depth    = 4096,
  parameter logic [DWidth-1:0] BaseAddr = 32'h0000_4000,
  parameter int                Latency  = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              write_i,
  input  logic [DWidth-1:0] addr_i,
  input  logic [DWidth-1:0] wdata_i,
  output logic              ready_o,
  output logic [DWidth-1:0] rdata_o,
  output logic              err_o,
  output logic              busy_o,
  output logic [31:0]       rd_cnt_o,
  output logic [31:0]       wr_cnt_o
);

  localparam int                c_aw     = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [3:0]        c_lat_m1 = 4'(Latency - 1);
  localparam logic [DWidth:0]   c_base   = {1'b0, BaseAddr};
  // One extra bit so the upper bound cannot wrap past the top of the address space.
  localparam logic [DWidth:0]   c_limit  = c_base + (DWidth+1)'(longint'(Depth) * 4);

  if ((Latency < 1) || (Latency > 15)) begin : g_latency_check
    $error("mem_resp_port: Latency must be within 1..15");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic                r_write;
  logic                r_in_range;
  logic [c_aw-1:0]     r_index;
  logic [DWidth-1:0]   r_wdata;
  logic                r_ready;
  logic                r_err;
  logic                r_busy;
  logic [DWidth-1:0]   r_rdata;
  logic [31:0]         r_rd_cnt;
  logic [31:0]         r_wr_cnt;
  logic [DWidth-1:0]   r_mem [Depth];

  logic                w_in_range;
  logic [c_aw-1:0]     w_index;
  logic                w_access;
  logic                w_commit;

  assign w_in_range = ({1'b0, addr_i} >= c_base) && ({1'b0, addr_i} < c_limit);
  assign w_index    = c_aw'((addr_i - BaseAddr) >> 2);
  assign w_access   = (r_state == S_WAIT) && (r_cnt == 4'd0);
  // Reset at the commit edge abandons the store.
  assign w_commit   = rst_ni && w_access && r_write && r_in_range;

  always_ff @(posedge clk_i) begin
    if (w_commit) begin
      r_mem[r_index] <= r_wdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_write    <= 1'b0;
      r_in_range <= 1'b0;
      r_index    <= '0;
      r_wdata    <= '0;
      r_ready    <= 1'b0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
      r_rdata    <= '0;
      r_rd_cnt   <= 32'd0;
      r_wr_cnt   <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_i) begin
            r_write    <= write_i;
            r_in_range <= w_in_range;
            r_index    <= w_index;
            r_wdata    <= wdata_i;
            r_cnt      <= c_lat_m1;
            r_busy     <= 1'b1;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            if (!r_write) begin
              r_rdata <= r_in_range ? r_mem[r_index] : '0;
            end
            r_ready <= 1'b1;
            r_err   <= !r_in_range;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
          if (r_write) begin
            r_wr_cnt <= r_wr_cnt + 32'd1;
          end else begin
            r_rd_cnt <= r_rd_cnt + 32'd1;
          end
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ready_o  = r_ready;
  assign rdata_o  = r_rdata;
  assign err_o    = r_err;
  assign busy_o   = r_busy;
  assign rd_cnt_o = r_rd_cnt;
  assign wr_cnt_o = r_wr_cnt;

endmodule

`default_nettype wire

// File: tb/tb_mem_resp_port.sv
// ============================================================================
// Module   : tb_mem_resp_port
// Brief    : Self-checking bench for mem_resp_port (Latency 3 and Latency 1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_resp_port;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_4000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n;
  logic        a_req, a_wr, a_ready, a_err, a_busy;
  logic [31:0] a_addr, a_wdata, a_rdata, a_rd_cnt, a_wr_cnt;
  logic        b_req, b_wr, b_ready, b_err, b_busy;
  logic [31:0] b_addr, b_wdata, b_rdata, b_rd_cnt, b_wr_cnt;

  mem_resp_port #(.DWidth(32), .Depth(DEPTH), .BaseAddr(BASE), .Latency(3)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(a_req), .write_i(a_wr), .addr_i(a_addr),
    .wdata_i(a_wdata), .ready_o(a_ready), .rdata_o(a_rdata), .err_o(a_err),
    .busy_o(a_busy), .rd_cnt_o(a_rd_cnt), .wr_cnt_o(a_wr_cnt));

  mem_resp_port #(.DWidth(32), .Depth(DEPTH), .BaseAddr(BASE), .Latency(1)) dut_l1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(b_req), .write_i(b_wr), .addr_i(b_addr),
    .wdata_i(b_wdata), .ready_o(b_ready), .rdata_o(b_rdata), .err_o(b_err),
    .busy_o(b_busy), .rd_cnt_o(b_rd_cnt), .wr_cnt_o(b_wr_cnt));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: word store keyed by word index, plus completion tallies.
  logic [31:0] m_mem [int];
  int unsigned m_rd = 0, m_wr = 0;
  logic [31:0] m_last = 32'd0;
  bit          m_last_known = 1'b1;

  function automatic bit m_in_range(input logic [31:0] a);
    return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + DEPTH * 4);
  endfunction

  task automatic model_apply(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                             output bit e_err, output logic [31:0] e_rd, output bit known);
    int idx;
    e_err = !m_in_range(a);
    idx   = int'((a - BASE) >> 2);
    if (wr) begin
      if (!e_err) m_mem[idx] = wd;
      m_wr++;
      e_rd  = m_last;
      known = m_last_known;
    end else begin
      if (e_err) begin
        e_rd = 32'd0; known = 1'b1;
      end else if (m_mem.exists(idx)) begin
        e_rd = m_mem[idx]; known = 1'b1;
      end else begin
        e_rd = 32'd0; known = 1'b0;
      end
      m_last = e_rd;
      m_last_known = known;
      m_rd++;
    end
  endtask

  // One complete transaction on the Latency=3 instance; returns the response.
  task automatic txn_a(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       input bit scramble, output logic [31:0] rd, output bit er);
    bit e_err, known, seen;
    logic [31:0] e_rd;
    int lat;
    model_apply(wr, a, wd, e_err, e_rd, known);
    a_req = 1'b1; a_wr = wr; a_addr = a; a_wdata = wd;
    lat = -1; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      if (i == 0 && scramble) begin
        a_addr = $urandom; a_wdata = $urandom;
      end
      if (a_ready) begin
        seen = 1'b1; lat = i;
      end
    end
    chk("latency", 32'(lat), 32'd3);
    rd = a_rdata; er = a_err;
    chk("err", 32'(er), 32'(e_err));
    if (known) chk("rdata", rd, e_rd);
    chk("busy_in_resp", 32'(a_busy), 32'd1);
    a_req = 1'b0;
    @(posedge clk); #1;
    chk("ready_one_cycle", 32'(a_ready), 32'd0);
    chk("busy_after", 32'(a_busy), 32'd0);
    chk("rd_cnt", a_rd_cnt, m_rd);
    chk("wr_cnt", a_wr_cnt, m_wr);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    bit er, e_err, known, seen;
    logic [31:0] e_rd;
    int t0, nready, extra;
    int rt[4];
    int bt[16];
    logic [31:0] bval[8];

    tbl.push_back('{1'b1, 32'h0000_4010, 32'hCAFE_F00D, 1'b0, 32'h0000_0000});
    tbl.push_back('{1'b0, 32'h0000_4010, 32'h0,         1'b0, 32'hCAFE_F00D});
    tbl.push_back('{1'b1, 32'h0000_40FC, 32'h1234_5678, 1'b0, 32'hCAFE_F00D});
    tbl.push_back('{1'b1, 32'h0000_4000, 32'hA5A5_A5A5, 1'b0, 32'hCAFE_F00D});
    tbl.push_back('{1'b0, 32'h0000_3FFC, 32'h0,         1'b1, 32'h0000_0000});
    tbl.push_back('{1'b1, 32'h0000_4100, 32'hDEAD_BEEF, 1'b1, 32'h0000_0000});
    tbl.push_back('{1'b0, 32'h0000_40FC, 32'h0,         1'b0, 32'h1234_5678});
    tbl.push_back('{1'b0, 32'h0000_4000, 32'h0,         1'b0, 32'hA5A5_A5A5});
    tbl.push_back('{1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0000_0000});
    tbl.push_back('{1'b0, 32'h0000_4013, 32'h0,         1'b0, 32'hCAFE_F00D});

    rst_n = 1'b0;
    a_req = 1'b0; a_wr = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_ready", 32'(a_ready), 32'd0);
    chk("rst_err", 32'(a_err), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_rdata", a_rdata, 32'd0);
    chk("rst_rd_cnt", a_rd_cnt, 32'd0);
    chk("rst_wr_cnt", a_wr_cnt, 32'd0);

    // Directed vectors
    foreach (tbl[k]) begin
      txn_a(tbl[k].wr, tbl[k].addr, tbl[k].wdata, 1'b0, rd, er);
      chk($sformatf("tbl%0d_err", k), 32'(er), 32'(tbl[k].exp_err));
      chk($sformatf("tbl%0d_rdata", k), rd, tbl[k].exp_rd);
    end

    // Inputs changed right after acceptance must not affect the access
    txn_a(1'b1, 32'h0000_4020, 32'h1111_2222, 1'b1, rd, er);
    txn_a(1'b0, 32'h0000_4020, 32'h0, 1'b0, rd, er);
    chk("scramble_rdata", rd, 32'h1111_2222);

    // req held high across four loads: accepts spaced Latency+2 apart
    a_req = 1'b1; a_wr = 1'b0; a_addr = 32'h0000_4010;
    t0 = cyc; nready = 0; extra = 0;
    for (int i = 0; i < 60 && nready < 4; i++) begin
      @(posedge clk); #1;
      if (a_ready) begin
        rt[nready] = cyc;
        model_apply(1'b0, 32'h0000_4010, 32'h0, e_err, e_rd, known);
        chk("held_rdata", a_rdata, e_rd);
        nready++;
        if (nready == 4) a_req = 1'b0;
      end
    end
    a_req = 1'b0;
    chk("held_count", 32'(nready), 32'd4);
    chk("held_first", 32'(rt[0] - t0), 32'd4);
    for (int k = 1; k < 4; k++) chk("held_spacing", 32'(rt[k] - rt[k-1]), 32'd5);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (a_ready) extra++;
    end
    chk("held_no_extra", 32'(extra), 32'd0);
    chk("held_rd_cnt", a_rd_cnt, m_rd);

    // Reset while a store is waiting: no write, no pulse, counters cleared
    a_req = 1'b1; a_wr = 1'b1; a_addr = 32'h0000_4010; a_wdata = 32'h0BAD_F00D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    a_req = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (a_ready) extra++;
    end
    m_rd = 0; m_wr = 0; m_last = 32'd0; m_last_known = 1'b1;
    chk("abort_no_ready", 32'(extra), 32'd0);
    chk("abort_rd_cnt", a_rd_cnt, 32'd0);
    chk("abort_wr_cnt", a_wr_cnt, 32'd0);
    chk("abort_busy", 32'(a_busy), 32'd0);
    chk("abort_rdata", a_rdata, 32'd0);
    txn_a(1'b0, 32'h0000_4010, 32'h0, 1'b0, rd, er);
    chk("abort_word_kept", rd, 32'hCAFE_F00D);

    // Randomized traffic against the model
    for (int k = 0; k < DEPTH; k++) txn_a(1'b1, BASE + 32'(k * 4), $urandom, 1'b0, rd, er);
    for (int k = 0; k < 150; k++) begin
      logic [31:0] ra;
      ra = BASE - 32'd16 + 32'($urandom_range(0, DEPTH + 7) * 4) + 32'($urandom_range(0, 3));
      txn_a(1'($urandom_range(0, 1)), ra, $urandom, 1'($urandom_range(0, 1)), rd, er);
    end

    // Latency=1 instance: alternating store/load with req held, period 3
    for (int k = 0; k < 8; k++) bval[k] = $urandom;
    b_req = 1'b1;
    t0 = cyc;
    for (int j = 0; j < 16; j++) begin
      b_wr    = (j % 2 == 0);
      b_addr  = BASE + 32'((j / 2) * 12);
      b_wdata = bval[j / 2];
      seen = 1'b0; bt[j] = -100;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(posedge clk); #1;
        if (b_ready) begin
          seen = 1'b1; bt[j] = cyc;
        end
      end
      chk("l1_err", 32'(b_err), 32'd0);
      if (!b_wr) chk("l1_rdata", b_rdata, bval[j / 2]);
      if (j == 0) chk("l1_first", 32'(bt[0] - t0), 32'd2);
      else        chk("l1_period", 32'(bt[j] - bt[j-1]), 32'd3);
    end
    b_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("l1_rd_cnt", b_rd_cnt, 32'd8);
    chk("l1_wr_cnt", b_wr_cnt, 32'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
